// File: rtl/trng_pkg.sv
// Shared CRC-8 constants and the bit-serial fold used by the entropy conditioner.
package trng_pkg;

  localparam int CRC_WIDTH = 8;
  localparam logic [CRC_WIDTH-1:0] CRC_POLY = 8'h07;
  localparam int FOLD_MAX_W = 1024;

  // Folds data[width-1:0] into crc MSB-first; width must be a constant at the call site.
  function automatic logic [CRC_WIDTH-1:0] crc8_fold(
    input logic [CRC_WIDTH-1:0]  crc,
    input logic [FOLD_MAX_W-1:0] data,
    input int                    width
  );
    logic [CRC_WIDTH-1:0] c;
    logic                 fb;
    c = crc;
    for (int i = width - 1; i >= 0; i--) begin
      fb = c[CRC_WIDTH-1] ^ data[i];
      c  = {c[CRC_WIDTH-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
    end
    return c;
  endfunction

endpackage

// File: rtl/trng_rep_test.sv
// Repetition-count health test: flags REP_LIMIT identical consecutive bytes, sticky until reset.
// o_trip is combinational for the current byte so the caller can suppress that byte.
module trng_rep_test #(
  parameter int REP_LIMIT = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_byte,
  input  logic       i_byte_vld,
  output logic       o_trip,
  output logic       o_alarm
);

  localparam int CW = $clog2(REP_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(REP_LIMIT);

  logic [7:0]    prev_q;
  logic          have_prev_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_next;
  logic          match;

  always_comb begin
    match    = have_prev_q && (i_byte == prev_q);
    cnt_next = CW'(1);
    if (match) cnt_next = (cnt_q == LIMIT) ? cnt_q : cnt_q + 1'b1;
    o_trip   = i_byte_vld && (cnt_next == LIMIT);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      cnt_q       <= '0;
      o_alarm     <= 1'b0;
    end else if (i_byte_vld) begin
      prev_q      <= i_byte;
      have_prev_q <= 1'b1;
      cnt_q       <= cnt_next;
      if (o_trip) o_alarm <= 1'b1;
    end
  end

endmodule

// File: rtl/trng_conditioner.sv
// Compresses NSRC raw source words into independent CRC-8 bytes packed OUT_BYTES per word.
// One-cycle latency from last sample to o_valid; a word completing while o_valid & !i_ready is dropped and counted.
module trng_conditioner
  import trng_pkg::*;
#(
  parameter int NSRC             = 1,
  parameter int SRC_WIDTH        = 32,
  parameter int SAMPLES_PER_BYTE = 1,
  parameter int OUT_BYTES        = 1,
  parameter int GUARD_CYCLES     = 8,
  parameter int REP_LIMIT        = 4,
  parameter int OVF_WIDTH        = 8
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_sample_en,
  input  logic [NSRC*SRC_WIDTH-1:0]   i_sampled,
  input  logic                        i_bypass,
  output logic [8*OUT_BYTES-1:0]      o_dat,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic                        o_guard,
  output logic                        o_alarm,
  output logic [OVF_WIDTH-1:0]        o_overflow_cnt
);

  localparam int DW = NSRC * SRC_WIDTH;
  localparam int SW = $clog2(SAMPLES_PER_BYTE + 1);
  localparam int BW = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;
  localparam int GW = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;
  localparam logic [SW-1:0] SAMP_LAST  = SW'(SAMPLES_PER_BYTE - 1);
  localparam logic [BW-1:0] BYTE_LAST  = BW'(OUT_BYTES - 1);
  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);

  logic [GW-1:0]          guard_cnt_q;
  logic [SW-1:0]          samp_cnt_q;
  logic [BW-1:0]          byte_idx_q;
  logic [CRC_WIDTH-1:0]   crc_q;
  logic                   byp_q;
  logic [8*OUT_BYTES-1:0] acc_q;

  logic [FOLD_MAX_W-1:0]  sample_ext;
  logic [CRC_WIDTH-1:0]   crc_seed;
  logic [CRC_WIDTH-1:0]   crc_next;
  logic [7:0]             byte_val;
  logic [8*OUT_BYTES-1:0] word_next;
  logic                   accept;
  logic                   first;
  logic                   byp_eff;
  logic                   byte_done;
  logic                   word_done;
  logic                   can_load;
  logic                   trip;

  assign sample_ext = FOLD_MAX_W'(i_sampled);

  always_comb begin
    accept    = i_sample_en && !o_guard;
    first     = (samp_cnt_q == '0);
    byp_eff   = first ? i_bypass : byp_q;
    crc_seed  = first ? '0 : crc_q;
    crc_next  = crc8_fold(crc_seed, sample_ext, DW);
    byte_done = accept && (samp_cnt_q == SAMP_LAST);
    byte_val  = byp_eff ? i_sampled[7:0] : crc_next;
    word_done = byte_done && (byte_idx_q == BYTE_LAST);
    word_next = acc_q;
    word_next[byte_idx_q*8 +: 8] = byte_val;
    can_load  = !o_valid || i_ready;
  end

  trng_rep_test #(.REP_LIMIT(REP_LIMIT)) u_rep_test (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_byte     (byte_val),
    .i_byte_vld (byte_done),
    .o_trip     (trip),
    .o_alarm    (o_alarm)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_guard        <= (GUARD_CYCLES != 0);
      guard_cnt_q    <= '0;
      samp_cnt_q     <= '0;
      byte_idx_q     <= '0;
      crc_q          <= '0;
      byp_q          <= 1'b0;
      acc_q          <= '0;
      o_dat          <= '0;
      o_valid        <= 1'b0;
      o_overflow_cnt <= '0;
    end else begin
      if (i_sample_en && o_guard) begin
        guard_cnt_q <= guard_cnt_q + 1'b1;
        if (guard_cnt_q == GUARD_LAST) o_guard <= 1'b0;
      end

      if (accept) begin
        if (first) byp_q <= i_bypass;
        crc_q      <= crc_next;
        samp_cnt_q <= byte_done ? '0 : samp_cnt_q + 1'b1;
        if (byte_done) begin
          byte_idx_q <= word_done ? '0 : byte_idx_q + 1'b1;
          acc_q      <= word_done ? '0 : word_next;
        end
      end

      // The tripping byte and everything after it must never reach the consumer.
      if (o_alarm || trip) begin
        o_valid <= 1'b0;
      end else if (word_done && can_load) begin
        o_valid <= 1'b1;
        o_dat   <= word_next;
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end

      if (word_done && !can_load && !o_alarm && !trip && (o_overflow_cnt != '1))
        o_overflow_cnt <= o_overflow_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_trng_conditioner.sv
// Directed bench: three conditioner configurations driven in turn against hand-computed CRC bytes.
module tb_trng_conditioner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // A: GUARD_CYCLES=2, one byte per word
  logic        a_rst, a_en, a_byp, a_rdy;
  logic [31:0] a_smp;
  logic [7:0]  a_dat;
  logic        a_vld, a_guard, a_alarm;
  logic [7:0]  a_ovf;

  // B: two bytes per word, no guard
  logic        b_rst, b_en, b_byp, b_rdy;
  logic [31:0] b_smp;
  logic [15:0] b_dat;
  logic        b_vld, b_guard, b_alarm;
  logic [7:0]  b_ovf;

  // C: four samples per byte, no guard
  logic        c_rst, c_en, c_byp, c_rdy;
  logic [31:0] c_smp;
  logic [7:0]  c_dat;
  logic        c_vld, c_guard, c_alarm;
  logic [7:0]  c_ovf;

  trng_conditioner #(.GUARD_CYCLES(2)) u_a (
    .i_clk(clk), .i_reset(a_rst), .i_sample_en(a_en), .i_sampled(a_smp), .i_bypass(a_byp),
    .o_dat(a_dat), .o_valid(a_vld), .i_ready(a_rdy), .o_guard(a_guard), .o_alarm(a_alarm),
    .o_overflow_cnt(a_ovf)
  );

  trng_conditioner #(.OUT_BYTES(2), .GUARD_CYCLES(0)) u_b (
    .i_clk(clk), .i_reset(b_rst), .i_sample_en(b_en), .i_sampled(b_smp), .i_bypass(b_byp),
    .o_dat(b_dat), .o_valid(b_vld), .i_ready(b_rdy), .o_guard(b_guard), .o_alarm(b_alarm),
    .o_overflow_cnt(b_ovf)
  );

  trng_conditioner #(.SAMPLES_PER_BYTE(4), .GUARD_CYCLES(0)) u_c (
    .i_clk(clk), .i_reset(c_rst), .i_sample_en(c_en), .i_sampled(c_smp), .i_bypass(c_byp),
    .o_dat(c_dat), .o_valid(c_vld), .i_ready(c_rdy), .o_guard(c_guard), .o_alarm(c_alarm),
    .o_overflow_cnt(c_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_samp(input logic [31:0] v);
    a_en = 1'b1; a_smp = v; step(); a_en = 1'b0;
  endtask

  task automatic b_samp(input logic [31:0] v);
    b_en = 1'b1; b_smp = v; step(); b_en = 1'b0;
  endtask

  task automatic c_samp(input logic [31:0] v);
    c_en = 1'b1; c_smp = v; step(); c_en = 1'b0;
  endtask

  int vld_cnt;

  initial begin
    a_rst = 1'b1; a_en = 1'b0; a_byp = 1'b0; a_rdy = 1'b0; a_smp = '0;
    b_rst = 1'b1; b_en = 1'b0; b_byp = 1'b0; b_rdy = 1'b0; b_smp = '0;
    c_rst = 1'b1; c_en = 1'b0; c_byp = 1'b0; c_rdy = 1'b0; c_smp = '0;
    step(); step();
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;

    // reset state
    chk("a_rst_guard", 32'(a_guard), 32'd1);
    chk("a_rst_valid", 32'(a_vld), 32'd0);
    chk("a_rst_dat",   32'(a_dat), 32'd0);
    chk("a_rst_alarm", 32'(a_alarm), 32'd0);
    chk("a_rst_ovf",   32'(a_ovf), 32'd0);
    chk("b_rst_guard", 32'(b_guard), 32'd0);

    // basic conversion through the guard period
    a_samp(32'h5);
    chk("a_guard_1", 32'(a_guard), 32'd1);
    a_samp(32'h5);
    chk("a_guard_2", 32'(a_guard), 32'd0);
    chk("a_guard_noval", 32'(a_vld), 32'd0);
    a_samp(32'h1);
    chk("a_basic_vld", 32'(a_vld), 32'd1);
    chk("a_basic_dat", 32'(a_dat), 32'h07);
    step();
    chk("a_basic_held", 32'(a_dat), 32'h07);
    a_rdy = 1'b1; step();
    chk("a_basic_xfer", 32'(a_vld), 32'd0);

    // repetition alarm on a constant source
    vld_cnt = 0;
    a_en = 1'b1; a_smp = 32'h0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (a_vld && a_dat == 8'h00) vld_cnt++;
      if (i == 3) chk("a_alarm_pre", 32'(a_alarm), 32'd0);
      if (i == 4) chk("a_alarm_set", 32'(a_alarm), 32'd1);
      if (i == 4) chk("a_alarm_noval", 32'(a_vld), 32'd0);
    end
    a_en = 1'b0;
    chk("a_alarm_words", 32'(vld_cnt), 32'd3);
    step();
    chk("a_alarm_sticky", 32'(a_alarm), 32'd1);

    // reset clears the alarm and restarts the guard, also mid-guard
    a_rst = 1'b1; a_rdy = 1'b0; step(); a_rst = 1'b0;
    chk("a_rst2_alarm", 32'(a_alarm), 32'd0);
    chk("a_rst2_guard", 32'(a_guard), 32'd1);
    a_samp(32'h9);
    a_rst = 1'b1; step(); a_rst = 1'b0;
    a_samp(32'h9);
    chk("a_regd_guard", 32'(a_guard), 32'd1);
    a_samp(32'h9);
    chk("a_regd_done", 32'(a_guard), 32'd0);
    a_samp(32'h2);
    chk("a_post_vld", 32'(a_vld), 32'd1);
    chk("a_post_dat", 32'(a_dat), 32'h0E);

    // backpressure and overflow
    b_samp(32'h1);
    chk("b_half_vld", 32'(b_vld), 32'd0);
    b_samp(32'h2);
    chk("b_w0_vld", 32'(b_vld), 32'd1);
    chk("b_w0_dat", 32'(b_dat), 32'h0E07);
    b_samp(32'h3); b_samp(32'h4);
    chk("b_ovf_1", 32'(b_ovf), 32'd1);
    b_samp(32'h5); b_samp(32'h6);
    chk("b_ovf_2", 32'(b_ovf), 32'd2);
    chk("b_held_dat", 32'(b_dat), 32'h0E07);
    chk("b_held_vld", 32'(b_vld), 32'd1);

    // word completes on the same edge as a transfer
    b_samp(32'h8);
    b_rdy = 1'b1;
    b_samp(32'h4);
    chk("b_sim_vld", 32'(b_vld), 32'd1);
    chk("b_sim_dat", 32'(b_dat), 32'h1C38);
    chk("b_sim_ovf", 32'(b_ovf), 32'd2);
    step();
    chk("b_sim_xfer", 32'(b_vld), 32'd0);

    // reset after one of two bytes
    b_samp(32'h1);
    b_rst = 1'b1; b_rdy = 1'b0; step(); b_rst = 1'b0;
    chk("b_rst_dat",  32'(b_dat), 32'd0);
    chk("b_rst_vld",  32'(b_vld), 32'd0);
    chk("b_rst_ovf",  32'(b_ovf), 32'd0);
    chk("b_rst_alarm", 32'(b_alarm), 32'd0);
    b_samp(32'h2); b_samp(32'h3);
    chk("b_post_vld", 32'(b_vld), 32'd1);
    chk("b_post_dat", 32'(b_dat), 32'h090E);

    // bypass latched at first sample of each byte
    chk("c_rst_guard", 32'(c_guard), 32'd0);
    c_byp = 1'b1; c_samp(32'h11111111);
    c_byp = 1'b0; c_samp(32'h22222222); c_samp(32'h33333333);
    chk("c_mid_vld", 32'(c_vld), 32'd0);
    c_samp(32'hDEADBEA5);
    chk("c_byp_vld", 32'(c_vld), 32'd1);
    chk("c_byp_dat", 32'(c_dat), 32'hA5);
    c_rdy = 1'b1;
    c_samp(32'h0);
    chk("c_byp_xfer", 32'(c_vld), 32'd0);
    c_byp = 1'b1; c_samp(32'h0); c_samp(32'h0); c_samp(32'h1);
    chk("c_crc_vld", 32'(c_vld), 32'd1);
    chk("c_crc_dat", 32'(c_dat), 32'h07);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
